// File: rtl/gpio_serial_loader.sv
// Shifts a captured pad-configuration image down the GPIO control-block chain,
// far block MSB first, then issues one load strobe. All outputs are registered.
module gpio_serial_loader #(
  parameter int NUM_GPIO      = 19,
  parameter int PAD_CTRL_BITS = 13,
  parameter int CLK_DIV       = 2
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              start,
  input  logic                              abort,
  input  logic [NUM_GPIO*PAD_CTRL_BITS-1:0] cfg_data,
  output logic                              busy,
  output logic                              done,
  output logic                              serial_clock,
  output logic                              serial_data,
  output logic                              serial_load
);

  localparam int N     = NUM_GPIO * PAD_CTRL_BITS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(CLK_DIV) + 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD_SETUP, LOAD_HI, DONE} state_t;
  typedef struct packed {
    logic busy;
    logic done;
    logic sclk;
    logic sdata;
    logic sload;
  } out_t;

  state_t           state, state_nxt;
  logic [N-1:0]     shadow, shadow_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  out_t             out_q, out_nxt;
  logic             phase_end;

  assign phase_end = (cnt == CNT_TOP);

  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    idx_nxt    = idx;
    unique case (state)
      IDLE: if (start && !abort) begin
        shadow_nxt = cfg_data;
        idx_nxt    = IDX_TOP;
        state_nxt  = SHIFT_LO;
      end
      SHIFT_LO:   if (phase_end) state_nxt = SHIFT_HI;
      SHIFT_HI: if (phase_end) begin
        if (idx != '0) begin
          idx_nxt   = idx - 1'b1;
          state_nxt = SHIFT_LO;
        end else begin
          state_nxt = LOAD_SETUP;
        end
      end
      LOAD_SETUP: if (phase_end) state_nxt = LOAD_HI;
      LOAD_HI:    if (phase_end) state_nxt = DONE;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
    // Abort drops the chain unloaded: no strobe, outputs return to idle levels.
    if (abort && state != IDLE) state_nxt = IDLE;

    cnt_nxt = (state_nxt != state || state_nxt == IDLE) ? '0 : cnt + 1'b1;

    out_nxt       = '0;
    out_nxt.busy  = state_nxt inside {SHIFT_LO, SHIFT_HI, LOAD_SETUP, LOAD_HI};
    out_nxt.done  = (state_nxt == DONE);
    out_nxt.sclk  = (state_nxt == SHIFT_HI);
    out_nxt.sload = (state_nxt == LOAD_HI);
    // Data changes only on SHIFT_LO entry so it is stable across the rising edge.
    if (state_nxt == SHIFT_LO && state != SHIFT_LO)
      out_nxt.sdata = shadow_nxt[idx_nxt];
    else if (state_nxt inside {SHIFT_LO, SHIFT_HI})
      out_nxt.sdata = out_q.sdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      shadow <= '0;
      idx    <= '0;
      cnt    <= '0;
      out_q  <= '0;
    end else begin
      state  <= state_nxt;
      shadow <= shadow_nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      out_q  <= out_nxt;
    end
  end

  assign busy         = out_q.busy;
  assign done         = out_q.done;
  assign serial_clock = out_q.sclk;
  assign serial_data  = out_q.sdata;
  assign serial_load  = out_q.sload;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench for gpio_serial_loader: two-block chain at CLK_DIV=2 and CLK_DIV=1,
// with a behavioural model of two chained gpio control blocks.
module tb_gpio_serial_loader;
  localparam int NG = 2;
  localparam int PB = 13;
  localparam int N  = NG * PB;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] cfg = '0;
  logic         sel = 1'b0;

  logic busy2, done2, sclk2, sdata2, sload2;
  logic busy1, done1, sclk1, sdata1, sload1;
  logic o_busy, o_done, o_sclk, o_sdata, o_sload;

  always #5 clk = ~clk;

  gpio_serial_loader #(.NUM_GPIO(NG), .PAD_CTRL_BITS(PB), .CLK_DIV(2)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort), .cfg_data(cfg),
    .busy(busy2), .done(done2), .serial_clock(sclk2), .serial_data(sdata2),
    .serial_load(sload2));

  gpio_serial_loader #(.NUM_GPIO(NG), .PAD_CTRL_BITS(PB), .CLK_DIV(1)) dut_d1 (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort), .cfg_data(cfg),
    .busy(busy1), .done(done1), .serial_clock(sclk1), .serial_data(sdata1),
    .serial_load(sload1));

  assign o_busy  = sel ? busy1  : busy2;
  assign o_done  = sel ? done1  : done2;
  assign o_sclk  = sel ? sclk1  : sclk2;
  assign o_sdata = sel ? sdata1 : sdata2;
  assign o_sload = sel ? sload1 : sload2;

  // Two chained control blocks fed by the CLK_DIV=2 loader.
  logic [PB-1:0] shift0 = '0, shift1 = '0, regs0 = '0, regs1 = '0;
  logic [2:0]    dm0, dm1;
  always @(posedge sclk2) begin
    shift0 <= {shift0[PB-2:0], sdata2};
    shift1 <= {shift1[PB-2:0], shift0[PB-1]};
  end
  always @(posedge sload2) begin
    regs0 <= shift0;
    regs1 <= shift1;
  end
  assign dm0 = regs0[12:10];
  assign dm1 = regs1[12:10];

  int checks = 0;
  int fails  = 0;

  int n_rise, n_load, n_done, busy_first, busy_last, busy_cnt;
  int load_first, load_last, load_cnt, done_cycle, hi_change;
  logic [N-1:0] stream;
  logic p_sclk, p_sload, p_sdata;

  // Cycle c is the interval after the c-th observed edge; inputs driven in
  // cycle c are captured at its closing edge.
  task automatic run(input int ncyc, input int s_a, input int s_b, input int s_c,
                     input int ab, input bit toggle);
    n_rise = 0; n_load = 0; n_done = 0; busy_cnt = 0; load_cnt = 0; hi_change = 0;
    busy_first = -1; busy_last = -1; load_first = -1; load_last = -1; done_cycle = -1;
    stream = '0;
    p_sclk = o_sclk; p_sload = o_sload; p_sdata = o_sdata;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (o_busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
        busy_cnt++;
      end
      if (o_sload) begin
        if (load_first < 0) load_first = c;
        load_last = c;
        load_cnt++;
        if (!p_sload) n_load++;
      end
      if (o_done) begin
        n_done++;
        done_cycle = c;
      end
      if (o_sclk && !p_sclk) begin
        n_rise++;
        stream = {stream[N-2:0], o_sdata};
        if (o_sdata !== p_sdata) hi_change++;
      end
      if (o_sclk && p_sclk && o_sdata !== p_sdata) hi_change++;
      p_sclk = o_sclk; p_sload = o_sload; p_sdata = o_sdata;
      start = (c == s_a) || (c == s_b) || (c == s_c);
      abort = (c == ab);
      if (toggle && c > 0) cfg = ~cfg;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    int i;
    sel = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy2, done2, sclk2, sdata2, sload2} !== 5'b0) begin
      fails++;
      $display("FAIL reset_state: got %b want 00000", {busy2, done2, sclk2, sdata2, sload2});
    end
    resetn = 1'b1;
    cfg = '1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (i = 0; i < 20 && !sclk2; i++) @(negedge clk);
    checks++;
    if (sclk2 !== 1'b1 || sdata2 !== 1'b1) begin
      fails++;
      $display("FAIL reach_shift_hi: sclk=%b sdata=%b want 1 1 within 20 cycles", sclk2, sdata2);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({busy2, done2, sclk2, sdata2, sload2} !== 5'b0) begin
      fails++;
      $display("FAIL async_reset: got %b want 00000", {busy2, done2, sclk2, sdata2, sload2});
    end
    @(negedge clk); resetn = 1'b1;
    run(30, -1, -1, -1, -1, 0);
    checks++;
    if (n_rise != 0 || busy_cnt != 0 || n_load != 0) begin
      fails++;
      $display("FAIL idle_after_reset: rises=%0d busy=%0d loads=%0d want 0 0 0",
               n_rise, busy_cnt, n_load);
    end
    run(20, 0, -1, -1, 0, 0);
    checks++;
    if (busy_cnt != 0 || n_rise != 0) begin
      fails++;
      $display("FAIL start_abort_idle: busy=%0d rises=%0d want 0 0", busy_cnt, n_rise);
    end
    run(10, -1, -1, -1, 3, 0);
    checks++;
    if (busy_cnt != 0 || n_done != 0) begin
      fails++;
      $display("FAIL abort_idle: busy=%0d done=%0d want 0 0", busy_cnt, n_done);
    end
  endtask

  task automatic test_basic();
    sel = 1'b0;
    cfg = 26'h2A5_1C3B;
    run(120, 0, -1, -1, -1, 0);
    checks++;
    if (busy_first != 1 || busy_last != 108 || busy_cnt != 108) begin
      fails++;
      $display("FAIL basic_busy: first=%0d last=%0d cnt=%0d want 1 108 108",
               busy_first, busy_last, busy_cnt);
    end
    checks++;
    if (n_rise != 26) begin
      fails++;
      $display("FAIL basic_rises: got %0d want 26", n_rise);
    end
    checks++;
    if (stream !== 26'h2A5_1C3B) begin
      fails++;
      $display("FAIL basic_stream: got %h want 2a51c3b", stream);
    end
    checks++;
    if (load_first != 107 || load_last != 108 || load_cnt != 2) begin
      fails++;
      $display("FAIL basic_load: first=%0d last=%0d cnt=%0d want 107 108 2",
               load_first, load_last, load_cnt);
    end
    checks++;
    if (n_done != 1 || done_cycle != 109) begin
      fails++;
      $display("FAIL basic_done: count=%0d cycle=%0d want 1 109", n_done, done_cycle);
    end
    checks++;
    if (hi_change != 0) begin
      fails++;
      $display("FAIL basic_data_stable: changes=%0d want 0", hi_change);
    end
  endtask

  task automatic test_end_to_end();
    sel = 1'b0;
    cfg = {13'h1803, 13'h0403};
    run(120, 0, -1, -1, -1, 0);
    checks++;
    if (regs1 !== 13'h1803 || regs0 !== 13'h0403) begin
      fails++;
      $display("FAIL e2e_regs: blk1=%h blk0=%h want 1803 0403", regs1, regs0);
    end
    checks++;
    if (dm1 !== 3'b110 || dm0 !== 3'b001) begin
      fails++;
      $display("FAIL e2e_dm: blk1=%b blk0=%b want 110 001", dm1, dm0);
    end
  endtask

  task automatic test_collisions();
    sel = 1'b0;
    cfg = 26'h15A_5A5A;
    run(120, 0, 5, 50, -1, 0);
    checks++;
    if (n_rise != 26 || n_load != 1 || n_done != 1 || done_cycle != 109) begin
      fails++;
      $display("FAIL start_ignored: rises=%0d loads=%0d done=%0d@%0d want 26 1 1@109",
               n_rise, n_load, n_done, done_cycle);
    end
    run(45, 0, -1, -1, 40, 0);
    checks++;
    if (busy_last != 40 || n_load != 0 || n_done != 0) begin
      fails++;
      $display("FAIL abort_busy: busy_last=%0d loads=%0d done=%0d want 40 0 0",
               busy_last, n_load, n_done);
    end
    run(120, 0, -1, -1, -1, 0);
    checks++;
    if (n_rise != 26 || busy_cnt != 108 || n_load != 1 || done_cycle != 109
        || stream !== 26'h15A_5A5A) begin
      fails++;
      $display("FAIL restart_after_abort: rises=%0d busy=%0d loads=%0d done@%0d stream=%h want 26 108 1 109 15a5a5a",
               n_rise, busy_cnt, n_load, done_cycle, stream);
    end
  endtask

  task automatic test_stability();
    sel = 1'b1;
    cfg = 26'h123_4567;
    run(70, 0, -1, -1, -1, 1);
    checks++;
    if (stream !== 26'h123_4567 || n_rise != 26) begin
      fails++;
      $display("FAIL d1_stream: got %h rises=%0d want 1234567 26", stream, n_rise);
    end
    checks++;
    if (hi_change != 0) begin
      fails++;
      $display("FAIL d1_data_stable: changes=%0d want 0", hi_change);
    end
    checks++;
    if (busy_cnt != 54 || busy_first != 1 || done_cycle != 55 || load_cnt != 1) begin
      fails++;
      $display("FAIL d1_timing: busy=%0d first=%0d done@%0d load=%0d want 54 1 55 1",
               busy_cnt, busy_first, done_cycle, load_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_end_to_end();
    test_collisions();
    test_stability();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
